// File: rtl/mem_copy_engine.sv
// Bus-master block engine: copies a block of words src->dst or fills dst with a constant,
// driving a single-port memory that writes on posedge and reads combinationally.
module mem_copy_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [15:0]       length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | waiting for start; all outputs 0
    // READ  | copy only: present src+cnt, capture mem_rdata into hold
    // WRITE | present dst+cnt with write enable; advance cnt
    // DONE  | one-cycle completion pulse, busy still high
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [15:0]       cnt;
    logic [DATA_W-1:0] hold;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [15:0]       len_q;
    logic              fill_q;
    logic [DATA_W-1:0] fval_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [15:0]       cnt_inc;
    logic              last_word;

    assign cnt_inc   = cnt + 16'd1;
    assign last_word = (cnt_inc == len_q);

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_addr = addr_q;
    // Reset must suppress the write already being presented so an abort never commits it.
    assign mem_we    = we_q & ~rst;
    assign mem_wdata = we_q ? (fill_q ? fval_q : hold) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hold   <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= 1'b0;
            fval_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            we_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    addr_q <= '0;
                    we_q   <= 1'b0;
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= length;
                        fill_q <= fill;
                        fval_q <= fill_value;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        if (length == 16'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (fill) begin
                            state  <= WRITE;
                            addr_q <= dst_addr;
                            we_q   <= 1'b1;
                        end else begin
                            state  <= READ;
                            addr_q <= src_addr;
                        end
                    end
                end
                READ: begin
                    hold   <= mem_rdata;
                    state  <= WRITE;
                    addr_q <= dst_q + ADDR_W'(cnt);
                    we_q   <= 1'b1;
                end
                WRITE: begin
                    cnt <= cnt_inc;
                    if (last_word) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        addr_q <= '0;
                        we_q   <= 1'b0;
                    end else if (fill_q) begin
                        addr_q <= dst_q + ADDR_W'(cnt_inc);
                    end else begin
                        state  <= READ;
                        addr_q <= src_q + ADDR_W'(cnt_inc);
                        we_q   <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    addr_q <= '0;
                    we_q   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    addr_q <= '0;
                    we_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory plus a word-level reference model of
// copy/fill results, table-driven and randomized commands, and reset corner cases.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst, start, fill;
    logic [15:0] src_addr, dst_addr, length, fill_value;
    logic        busy, done, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .fill(fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        mem_init, poke_en;
    logic [15:0] poke_addr, poke_data;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'(i * 7) ^ 16'h3C5A;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (poke_en) mem[poke_addr] <= poke_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Reference: words move one at a time in ascending order, addresses wrap at 16 bits.
    task automatic ref_apply(input bit f, input logic [15:0] s, input logic [15:0] d,
                             input logic [15:0] n, input logic [15:0] v);
        logic [15:0] k;
        for (int i = 0; i < int'(n); i++) begin
            k = 16'(i);
            ref_mem[16'(d + k)] = f ? v : ref_mem[16'(s + k)];
        end
    endtask

    task automatic compare_mem(input string name);
        int diffs = 0;
        int first = -1;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                diffs++;
                if (first < 0) first = i;
            end
        end
        if (diffs != 0) $display("  first differing address 0x%0h", first);
        chk({name, "_mem_diffs"}, 64'(diffs), 64'd0);
    endtask

    task automatic run_cmd(input string name, input bit f, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] n, input logic [15:0] v,
                           input int exp_done, input int exp_we, input bit disturb);
        int c = 0;
        int done_c = -1;
        int we_n = 0;
        int busy_bad = 0;
        int idle_bad = 0;
        @(negedge clk);
        start = 1'b1; fill = f; src_addr = s; dst_addr = d; length = n; fill_value = v;
        @(posedge clk);
        while (done_c < 0 && c < 300) begin
            @(negedge clk);
            c++;
            if (mem_we) we_n++;
            if (!busy) busy_bad++;
            if (done) done_c = c;
            // Changing command inputs after acceptance must have no effect.
            start      = disturb && (c <= exp_done);
            fill       = 1'($urandom);
            src_addr   = 16'($urandom);
            dst_addr   = 16'($urandom);
            length     = 16'($urandom_range(1, 4));
            fill_value = 16'($urandom);
        end
        chk({name, "_done_cycle"}, 64'(done_c), 64'(exp_done));
        chk({name, "_we_cycles"}, 64'(we_n), 64'(exp_we));
        chk({name, "_busy_gaps"}, 64'(busy_bad), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || done || mem_we) idle_bad++;
        end
        chk({name, "_idle_after"}, 64'(idle_bad), 64'd0);
        ref_apply(f, s, d, n, v);
        compare_mem(name);
    endtask

    typedef struct {
        string       name;
        bit          f;
        logic [15:0] s, d, n, v;
        int          exp_done, exp_we;
        bit          disturb;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{"copy4",      1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0000,  9, 4, 1'b0};
        tbl[1] = '{"fill3",      1'b1, 16'h0000, 16'h0200, 16'd3, 16'h5A5A,  4, 3, 1'b0};
        tbl[2] = '{"zero_len",   1'b0, 16'h1234, 16'h2000, 16'd0, 16'h0000,  1, 0, 1'b0};
        tbl[3] = '{"wrap_copy",  1'b0, 16'hFFFE, 16'h0300, 16'd4, 16'h0000,  9, 4, 1'b0};
        tbl[4] = '{"overlap",    1'b0, 16'h0100, 16'h0102, 16'd5, 16'h0000, 11, 5, 1'b0};
        tbl[5] = '{"wrap_fill",  1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h1111,  5, 4, 1'b0};
        tbl[6] = '{"ign_start",  1'b0, 16'h0800, 16'h0900, 16'd3, 16'h0000,  7, 3, 1'b1};
        tbl[7] = '{"ign_zero",   1'b0, 16'h0800, 16'h0A00, 16'd0, 16'h0000,  1, 0, 1'b1};
        tbl[8] = '{"ign_fill1",  1'b1, 16'h0000, 16'h0A00, 16'd1, 16'hBEEF,  2, 1, 1'b1};
        tbl[9] = '{"self_copy",  1'b0, 16'h0B00, 16'h0B00, 16'd1, 16'h0000,  3, 1, 1'b0};

        rst = 1'b1; start = 1'b1; fill = 1'b1; src_addr = 16'h1111; dst_addr = 16'h2222;
        length = 16'd5; fill_value = 16'hFFFF; mem_init = 1'b1; poke_en = 1'b0;
        poke_addr = '0; poke_data = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i * 7) ^ 16'h3C5A;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {29'd0, busy, done, mem_we, mem_addr, mem_wdata}, 64'd0);
        mem_init = 1'b0; rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_idle_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), 16'hA000 + 16'(i));
        poke(16'hFFFE, 16'd1);
        poke(16'hFFFF, 16'd2);
        poke(16'h0000, 16'd3);
        poke(16'h0001, 16'd4);

        for (int i = 0; i < 10; i++)
            run_cmd(tbl[i].name, tbl[i].f, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].v,
                    tbl[i].exp_done, tbl[i].exp_we, tbl[i].disturb);

        // Abort a 6-word copy while word 2 is being written.
        begin
            int c = 0;
            int late_bad = 0;
            @(negedge clk);
            start = 1'b1; fill = 1'b0; src_addr = 16'h0600; dst_addr = 16'h0700; length = 16'd6;
            @(posedge clk);
            while (c < 6) begin
                @(negedge clk);
                c++;
                start = 1'b0;
            end
            chk("abort_we_word2", {63'd0, mem_we}, 64'd1);
            chk("abort_addr_word2", {48'd0, mem_addr}, 64'h0702);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_outputs", {29'd0, busy, done, mem_we, mem_addr, mem_wdata}, 64'd0);
            rst = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (busy || done || mem_we) late_bad++;
            end
            chk("abort_quiet", 64'(late_bad), 64'd0);
            ref_apply(1'b0, 16'h0600, 16'h0700, 16'd2, 16'd0);
            compare_mem("abort");
        end

        for (int i = 0; i < 12; i++) begin
            bit          f;
            logic [15:0] n;
            int          ed;
            f  = 1'($urandom);
            n  = 16'($urandom_range(0, 12));
            ed = (n == 0) ? 1 : (f ? int'(n) + 1 : 2 * int'(n) + 1);
            run_cmd($sformatf("rand%0d", i), f, 16'($urandom), 16'($urandom), n,
                    16'($urandom), ed, int'(n), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
